seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier with valid/ready handshakes and a per-operation signed/unsigned mode. It produces the full double-width product, a truncated WIDTH-bit result and an overflow flag. It replaces the fixed 5x5 combinational multiplier as the arithmetic core behind the board's switch/LED top level. One operation is in flight at a time, trading latency for area.

---
 rtl/mult_pkg.sv | 33 +++
 rtl/seq_multiplier.sv | 100 ++++++++++
 tb/tb_seq_multiplier.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM states
// and the overflow rule used by the datapath.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Overflow of a 2*width-bit product reduced to width bits.
    // Unsigned: any bit above the low width bits is set.
    // Signed: bits [2w-1:w-1] are not a pure sign extension.
    function automatic logic calc_overflow(input logic [63:0] p,
                                           input int          width,
                                           input logic        signed_mode);
        logic ovf;
        logic msb;
        ovf = 1'b0;
        msb = p[6'(2 * width - 1)];
        for (int i = 0; i < 64; i++) begin
            if (signed_mode) begin
                if (i >= width - 1 && i < 2 * width && p[i[5:0]] != msb)
                    ovf = 1'b1;
            end else begin
                if (i >= width && i < 2 * width && p[i[5:0]])
                    ovf = 1'b1;
            end
        end
        return ovf;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier with valid/ready handshakes.
// Operands are reduced to magnitudes on accept, multiplied unsigned over
// WIDTH steps, and the sign is reapplied on the final step.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic [WIDTH-1:0]     out,
    output logic                 overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2 * WIDTH)'(1);

    mult_state_t          state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic                 neg;
    logic                 mode_q;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   result;

    // Operand magnitudes, the current partial sum and the sign-corrected product.
    always_comb begin
        a_mag   = (signed_mode && a[WIDTH-1]) ? (~a + ONE_W) : a;
        b_mag   = (signed_mode && b[WIDTH-1]) ? (~b + ONE_W) : b;
        acc_sum = mplier[0] ? (acc + mcand) : acc;
        result  = neg ? (~acc_sum + ONE_2W) : acc_sum;
    end

    // Handshake flags and the truncated result are decoded from registers only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out       = prod[WIDTH-1:0];

    // Control FSM and datapath registers: accept, WIDTH shift-add steps, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            mode_q   <= 1'b0;
            prod     <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        mode_q <= signed_mode;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        prod     <= result;
                        overflow <= calc_overflow(64'(result), WIDTH, mode_q);
                        cnt      <= '0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=5 and WIDTH=8: fixed
// vector table, backpressure and reset sequences, and a random sweep
// against an integer-arithmetic reference model.
module tb_seq_multiplier;

    logic clk;
    logic rst;

    logic        in_valid5, in_ready5, sm5, out_valid5, out_ready5, ovf5;
    logic [4:0]  a5, b5, out5;
    logic [9:0]  prod5;

    logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8, ovf8;
    logic [7:0]  a8, b8, out8;
    logic [15:0] prod8;

    int compared;
    int mismatched;

    typedef struct {
        string  name;
        int     a;
        int     b;
        bit     sm;
        longint exp_prod;
        longint exp_out;
        bit     exp_ovf;
    } vec_t;

    vec_t vecs[$];

    seq_multiplier #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid5), .in_ready(in_ready5),
        .a(a5), .b(b5), .signed_mode(sm5),
        .out_valid(out_valid5), .out_ready(out_ready5),
        .prod(prod5), .out(out5), .overflow(ovf5)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .signed_mode(sm8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .prod(prod8), .out(out8), .overflow(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint get_prod(int sel);
        return (sel == 8) ? longint'(prod8) : longint'(prod5);
    endfunction

    function automatic longint get_out(int sel);
        return (sel == 8) ? longint'(out8) : longint'(out5);
    endfunction

    function automatic longint get_ovf(int sel);
        return (sel == 8) ? longint'(ovf8) : longint'(ovf5);
    endfunction

    function automatic longint get_out_valid(int sel);
        return (sel == 8) ? longint'(out_valid8) : longint'(out_valid5);
    endfunction

    function automatic longint get_in_ready(int sel);
        return (sel == 8) ? longint'(in_ready8) : longint'(in_ready5);
    endfunction

    // Reference: interpret operands as integers, multiply, then truncate.
    function automatic void ref_model(input int w, input int a, input int b, input bit sm,
                                      output longint p, output longint o, output bit ov);
        longint sa, sb, full, lim;
        sa = a;
        sb = b;
        if (sm && a >= (1 << (w - 1))) sa = longint'(a) - (64'sd1 <<< w);
        if (sm && b >= (1 << (w - 1))) sb = longint'(b) - (64'sd1 <<< w);
        full = sa * sb;
        p = full & ((64'sd1 <<< (2 * w)) - 1);
        o = full & ((64'sd1 <<< w) - 1);
        lim = 64'sd1 <<< (w - 1);
        if (sm) ov = (full < -lim) || (full > lim - 1);
        else    ov = (full >= (64'sd1 <<< w));
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_inputs(input int sel, input bit v, input int a, input int b, input bit sm);
        if (sel == 8) begin
            in_valid8 = v; a8 = 8'(a); b8 = 8'(b); sm8 = sm;
        end else begin
            in_valid5 = v; a5 = 5'(a); b5 = 5'(b); sm5 = sm;
        end
    endtask

    task automatic set_out_ready(input int sel, input bit r);
        if (sel == 8) out_ready8 = r;
        else          out_ready5 = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid; returns edges counted since the accept edge, or -1.
    task automatic wait_result(input int sel, output int lat);
        lat = 0;
        while (get_out_valid(sel) == 0 && lat < 100) begin
            step();
            lat++;
        end
        if (get_out_valid(sel) == 0) lat = -1;
    endtask

    // One accept: wait for in_ready, present operands for one edge, wait for result.
    task automatic applyStimulus(input int sel, input int a, input int b, input bit sm,
                                 output int lat);
        int guard;
        guard = 0;
        while (get_in_ready(sel) == 0 && guard < 50) begin
            step();
            guard++;
        end
        set_inputs(sel, 1'b1, a, b, sm);
        step();
        set_inputs(sel, 1'b0, 0, 0, 1'b0);
        wait_result(sel, lat);
    endtask

    task automatic finish_op(input int sel, input string name);
        set_out_ready(sel, 1'b1);
        step();
        set_out_ready(sel, 1'b0);
        checkOutput({name, " out_valid after handshake"}, get_out_valid(sel), 0);
        checkOutput({name, " in_ready after handshake"}, get_in_ready(sel), 1);
    endtask

    task automatic run_vector(input int sel, input string name, input int a, input int b,
                              input bit sm, input longint ep, input longint eo, input bit ev);
        int lat;
        applyStimulus(sel, a, b, sm, lat);
        checkOutput({name, " latency"}, lat, sel);
        checkOutput({name, " prod"}, get_prod(sel), ep);
        checkOutput({name, " out"}, get_out(sel), eo);
        checkOutput({name, " overflow"}, get_ovf(sel), longint'(ev));
        finish_op(sel, name);
    endtask

    task automatic run_random(input int sel, input string name, input int a, input int b,
                              input bit sm);
        longint p, o;
        bit ov;
        ref_model(sel, a, b, sm, p, o, ov);
        run_vector(sel, name, a, b, sm, p, o, ov);
    endtask

    initial begin
        int lat;
        compared   = 0;
        mismatched = 0;
        rst = 1'b0;
        set_inputs(5, 1'b0, 0, 0, 1'b0);
        set_inputs(8, 1'b0, 0, 0, 1'b0);
        out_ready5 = 1'b0;
        out_ready8 = 1'b0;

        vecs.push_back('{"u 7x3",     7,  3,  1'b0, 21,    21, 1'b0});
        vecs.push_back('{"u 7x5",     7,  5,  1'b0, 35,    3,  1'b1});
        vecs.push_back('{"u 31x31",   31, 31, 1'b0, 961,   1,  1'b1});
        vecs.push_back('{"s -3x5",    29, 5,  1'b1, 'h3F1, 17, 1'b0});
        vecs.push_back('{"s -16x-1",  16, 31, 1'b1, 16,    16, 1'b1});
        vecs.push_back('{"s -16x1",   16, 1,  1'b1, 'h3F0, 16, 1'b0});
        vecs.push_back('{"s 0x-16",   0,  16, 1'b1, 0,     0,  1'b0});
        vecs.push_back('{"s -1x-1",   31, 31, 1'b1, 1,     1,  1'b0});
        vecs.push_back('{"s -16x-16", 16, 16, 1'b1, 256,   0,  1'b1});

        #3 rst = 1'b1;
        #10;
        checkOutput("reset in_ready", longint'(in_ready5), 1);
        checkOutput("reset out_valid", longint'(out_valid5), 0);
        checkOutput("reset prod", longint'(prod5), 0);
        checkOutput("reset out", longint'(out5), 0);
        checkOutput("reset overflow", longint'(ovf5), 0);
        checkOutput("reset prod w8", longint'(prod8), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        foreach (vecs[i])
            run_vector(5, vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sm,
                       vecs[i].exp_prod, vecs[i].exp_out, vecs[i].exp_ovf);

        // Backpressure with in_valid held high (new operands) through BUSY and DONE.
        set_inputs(5, 1'b1, 7, 3, 1'b0);
        step();
        set_inputs(5, 1'b1, 31, 31, 1'b1);
        wait_result(5, lat);
        checkOutput("bp latency", lat, 5);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp out_valid held", get_out_valid(5), 1);
            checkOutput("bp prod held", get_prod(5), 21);
            checkOutput("bp out held", get_out(5), 21);
            checkOutput("bp overflow held", get_ovf(5), 0);
            step();
        end
        set_inputs(5, 1'b0, 0, 0, 1'b0);
        finish_op(5, "bp");
        checkOutput("bp prod after release", get_prod(5), 21);
        step();
        checkOutput("bp no queued op", get_in_ready(5), 1);

        // Asynchronous reset in the middle of BUSY, released mid-cycle.
        set_inputs(5, 1'b1, 9, 9, 1'b0);
        step();
        set_inputs(5, 1'b0, 0, 0, 1'b0);
        step();
        step();
        checkOutput("busy in_ready", get_in_ready(5), 0);
        #1 rst = 1'b1;
        #1;
        checkOutput("async rst in_ready", get_in_ready(5), 1);
        checkOutput("async rst out_valid", get_out_valid(5), 0);
        checkOutput("async rst prod", get_prod(5), 0);
        #2 rst = 1'b0;
        step();
        run_vector(5, "after rst 2x2", 2, 2, 1'b0, 4, 4, 1'b0);

        // Width-8 corners and random sweeps at both widths.
        run_vector(8, "w8 u 255x255", 255, 255, 1'b0, 65025, 1, 1'b1);
        run_random(8, "w8 s -128x-128", 128, 128, 1'b1);
        run_random(8, "w8 s -128x-1", 128, 255, 1'b1);
        run_random(8, "w8 s -128x1", 128, 1, 1'b1);
        for (int i = 0; i < 40; i++)
            run_random(8, "w8 random", int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 20; i++)
            run_random(5, "w5 random", int'($urandom_range(0, 31)),
                       int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
